// File: rtl/inv_add_mix_round.sv
// inv_add_mix_round: decryption round back-end.
//
// Applies AddRoundKey to the invSubBytes state when a block is accepted. On a normal round it
// then applies InvMixColumns. On the final round (last_round=1) that step is skipped.
// The block has a single-entry buffer, with a valid/ready handshake on both sides.
//
// Ports:
//   clk        - system clock; all logic on the rising edge
//   rst        - synchronous, active-high reset
//   in_valid   - in_state/round_key/last_round valid
//   in_ready   - block idle and able to accept
//   in_state   - invSubBytes output; byte 0 = bits 127:120, column c = bits 127-32c : 96-32c
//   round_key  - round key for this round
//   last_round - 1 = skip InvMixColumns
//   out_valid  - out_state valid
//   out_ready  - consumer accepts out_state
//   out_state  - round result
//
// Parameter KEY_REG:
//   1 = round_key is captured with the state at accept.
//   0 = upstream holds round_key until out_valid.
//
// Build option INV_ADD_MIX_PARALLEL_EN:
//   Defined   - all four columns are mixed in one cycle, using four InvMixColumns instances.
//   Undefined - one column is mixed per cycle through a single shared instance.

module inv_add_mix_round #(
  parameter int unsigned KEY_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {StIdle, StMix, StDone} state_e;

  state_e       state_q;
  logic [127:0] work_q;
  logic [127:0] ark;
  logic [127:0] mixed;

  // GF(2^8) multiply by x, reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns on one column; s0 is the most significant byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] s [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31-8*i -: 8];
      x2    = xtime(s[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // AddRoundKey is folded into the accept edge, so the key value is snapshotted either way.
  // KEY_REG therefore only changes what upstream is promised, not the datapath.
  if (KEY_REG != 0) begin : g_key_reg
    assign ark = in_state ^ round_key;
  end else begin : g_key_live
    assign ark = in_state ^ round_key;
  end

`ifdef INV_ADD_MIX_PARALLEL_EN
  always_comb begin
    mixed = {inv_mix_col(work_q[127:96]), inv_mix_col(work_q[95:64]),
             inv_mix_col(work_q[63:32]),  inv_mix_col(work_q[31:0])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      work_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            work_q  <= ark;
            state_q <= last_round ? StDone : StMix;
          end
        end
        StMix: begin
          work_q  <= mixed;
          state_q <= StDone;
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  logic [1:0]  col_q;
  logic [31:0] col_in;
  logic [31:0] col_out;

  // One shared InvMixColumns instance.
  // The current column is muxed into it, and the result is written back in place.
  always_comb begin
    col_in = work_q[127:96];
    unique case (col_q)
      2'd0: col_in = work_q[127:96];
      2'd1: col_in = work_q[95:64];
      2'd2: col_in = work_q[63:32];
      2'd3: col_in = work_q[31:0];
      default: col_in = work_q[127:96];
    endcase
  end

  assign col_out = inv_mix_col(col_in);

  always_comb begin
    mixed = work_q;
    unique case (col_q)
      2'd0: mixed[127:96] = col_out;
      2'd1: mixed[95:64]  = col_out;
      2'd2: mixed[63:32]  = col_out;
      2'd3: mixed[31:0]   = col_out;
      default: mixed = work_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      col_q   <= 2'd0;
      work_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            work_q  <= ark;
            col_q   <= 2'd0;
            state_q <= last_round ? StDone : StMix;
          end
        end
        StMix: begin
          work_q <= mixed;
          col_q  <= col_q + 2'd1;  // wraps to 0 after column 3
          if (col_q == 2'd3) state_q <= StDone;
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`endif

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign out_state = work_q;

endmodule

// File: tb/tb_inv_add_mix_round.sv
// Directed testbench for inv_add_mix_round. Compile with the same defines as the RTL.
module tb_inv_add_mix_round;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] round_key;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef INV_ADD_MIX_PARALLEL_EN
  localparam int NormLat = 2;
`else
  localparam int NormLat = 5;
`endif

  localparam logic [127:0] V1In   = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] V1Exp  = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] V2In   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] V2Key  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] V2Exp  = 128'h00102030_40506070_8090a0b0_c0d0e0f0;
  localparam logic [127:0] V3Key  = 128'hffffffff_00000000_00000000_00000000;
  // InvMixColumns(71b25e43) = InvMixColumns(8e4da1bc) ^ InvMixColumns(ffffffff)
  //                         = db135345 ^ ffffffff
  localparam logic [127:0] V3Exp  = 128'h24ecacba_f20a225c_01010101_d4d4d4d5;

  inv_add_mix_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .round_key (round_key),
    .last_round(last_round),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one block, then scramble the inputs.
  // Count edges until out_valid (the accept edge is edge 1), then check the latency and result.
  task automatic run_block(input string tag, input logic [127:0] st, input logic [127:0] key,
                           input logic last, input logic [127:0] exp, input int exp_lat);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    in_state   = st;
    round_key  = key;
    last_round = last;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
    in_state   = {$urandom, $urandom, $urandom, $urandom};
    round_key  = {$urandom, $urandom, $urandom, $urandom};
    last_round = ~last;
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk({tag, "_busy"}, 128'(in_ready), 128'(0));
      step();
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_out"}, out_state, exp);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 128'(out_valid), 128'(0));
    chk({tag, "_ready_back"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_state   = '0;
    round_key  = '0;
    last_round = 1'b0;
    out_ready  = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_state", out_state, 128'h0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));

    // Normal round, zero key
    run_block("mix", V1In, 128'h0, 1'b0, V1Exp, NormLat);
    release_out("mix");

    // Last round: AddRoundKey only
    run_block("last", V2In, V2Key, 1'b1, V2Exp, 1);
    release_out("last");

    // AddRoundKey feeding InvMixColumns
    run_block("comb", V1In, V3Key, 1'b0, V3Exp, NormLat);
    release_out("comb");

    // Backpressure: out_state is held, and a second offer is refused while in DONE
    run_block("bp", V1In, 128'h0, 1'b0, V1Exp, NormLat);
    in_state   = V2In;
    round_key  = V2Key;
    last_round = 1'b1;
    in_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_state", out_state, V1Exp);
      chk("bp_hold_ready", 128'(in_ready), 128'(0));
      chk("bp_hold_valid", 128'(out_valid), 128'(1));
    end
    in_valid = 1'b0;
    release_out("bp");
    step();
    chk("bp_no_second", 128'(out_valid), 128'(0));

    // Reset during MIX; out_ready is asserted there too and must be ignored
    in_state   = V1In;
    round_key  = 128'h0;
    last_round = 1'b0;
    in_valid   = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifndef INV_ADD_MIX_PARALLEL_EN
    step();
    step();
    chk("midmix_busy", 128'(out_valid), 128'(0));
`endif
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_out_state", out_state, 128'h0);
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    step();
    chk("midrst_release_ready", 128'(in_ready), 128'(1));
    chk("midrst_no_pulse", 128'(out_valid), 128'(0));
    run_block("fresh", V1In, V3Key, 1'b0, V3Exp, NormLat);
    release_out("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
